// File: rtl/timer_event_counter.sv
// ---------------------------------------------------------------------------
// timer_event_counter
//
// Counting stage that sits behind the timer input stage. A NUM_BITS counter
// is advanced by the per-cycle event qualifier. It runs between shadowed
// start/end thresholds in either a sawtooth shape or a triangle shape.
//
// Optional feature (macro TIMER_EVENT_COUNTER_PRESC_EN):
//   Adds an 8-bit event prescaler. The counter then steps once every
//   r_presc+1 qualified events. When the macro is undefined, cfg_presc_i is
//   ignored and every qualified event is a step.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   ctrl_active_i  counting enable; steps are ignored while low
//   ctrl_update_i  load shadow config and restart the counter at cfg_start_i
//   ctrl_rst_i     restart the counter at r_start, keeping the config
//   cfg_start_i    start threshold
//   cfg_end_i      end threshold
//   cfg_saw_i      1 = sawtooth, 0 = triangle
//   cfg_presc_i    event prescale value (optional feature only)
//   event_i        step qualifier from the input stage
//   counter_o      current count
//   direction_o    0 = counting up, 1 = counting down
//   end_o          registered one-cycle end-of-period pulse
// ---------------------------------------------------------------------------
module timer_event_counter #(
    parameter int NUM_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ctrl_active_i,
    input  logic                ctrl_update_i,
    input  logic                ctrl_rst_i,
    input  logic [NUM_BITS-1:0] cfg_start_i,
    input  logic [NUM_BITS-1:0] cfg_end_i,
    input  logic                cfg_saw_i,
    input  logic [7:0]          cfg_presc_i,
    input  logic                event_i,
    output logic [NUM_BITS-1:0] counter_o,
    output logic                direction_o,
    output logic                end_o
);

    localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

    logic [NUM_BITS-1:0] r_start;
    logic [NUM_BITS-1:0] r_end;
    logic                r_saw;
    logic [NUM_BITS-1:0] cnt;
    logic                dir;
    logic                end_q;
    logic                tick;
    logic                step;
    logic                tri_mode;

`ifdef TIMER_EVENT_COUNTER_PRESC_EN
    logic [7:0] r_presc;
    logic [7:0] presc_cnt;

    // The prescaler counts every qualified event. A tick occurs on the event
    // that finds the count equal to r_presc. The count then returns to 0.
    assign tick = (presc_cnt == r_presc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc   <= 8'd0;
            presc_cnt <= 8'd0;
        end else if (ctrl_update_i) begin
            r_presc   <= cfg_presc_i;
            presc_cnt <= 8'd0;
        end else if (ctrl_rst_i) begin
            presc_cnt <= 8'd0;
        end else if (ctrl_active_i && event_i) begin
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
        end
    end
`else
    logic [7:0] unused_presc;
    assign unused_presc = cfg_presc_i;
    assign tick         = 1'b1;
`endif

    assign step = ctrl_active_i & event_i & tick;

    // A degenerate triangle (start >= end) runs exactly like a sawtooth.
    assign tri_mode = !r_saw && (r_start < r_end);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start <= '0;
            r_end   <= '0;
            r_saw   <= 1'b1;
            cnt     <= '0;
            dir     <= 1'b0;
            end_q   <= 1'b0;
        end else if (ctrl_update_i) begin
            r_start <= cfg_start_i;
            r_end   <= cfg_end_i;
            r_saw   <= cfg_saw_i;
            cnt     <= cfg_start_i;   // new value, not the old shadow
            dir     <= 1'b0;
            end_q   <= 1'b0;
        end else if (ctrl_rst_i) begin
            cnt     <= r_start;
            dir     <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            if (step) begin
                if (!tri_mode) begin
                    dir <= 1'b0;
                    if (cnt == r_end) begin
                        cnt   <= r_start;
                        end_q <= 1'b1;
                    end else begin
                        cnt   <= cnt + ONE;   // wraps through all-ones when start > end
                    end
                end else if (!dir) begin
                    if (cnt == r_end) begin
                        dir <= 1'b1;
                        cnt <= cnt - ONE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end else begin
                    if (cnt == r_start) begin
                        dir   <= 1'b0;
                        cnt   <= cnt + ONE;
                        end_q <= 1'b1;
                    end else begin
                        cnt   <= cnt - ONE;
                    end
                end
            end
        end
    end

    assign counter_o   = cnt;
    assign direction_o = dir;
    assign end_o       = end_q;

endmodule

// File: tb/tb_timer_event_counter.sv
module tb_timer_event_counter;

    logic        clk_i = 1'b0;
    logic        rst_i, ctrl_active_i, ctrl_update_i, ctrl_rst_i;
    logic [15:0] cfg_start_i, cfg_end_i;
    logic        cfg_saw_i;
    logic [7:0]  cfg_presc_i;
    logic        event_i;
    logic [15:0] counter_o;
    logic        direction_o, end_o;

    always #5 clk_i = ~clk_i;

    timer_event_counter #(.NUM_BITS(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_active_i(ctrl_active_i),
        .ctrl_update_i(ctrl_update_i), .ctrl_rst_i(ctrl_rst_i),
        .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_saw_i(cfg_saw_i),
        .cfg_presc_i(cfg_presc_i), .event_i(event_i),
        .counter_o(counter_o), .direction_o(direction_o), .end_o(end_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. The state is the number of steps taken since the last
    // restart (m_p). Outputs come from the period geometry using arithmetic.
    longint m_s, m_e, m_presc, m_p, m_qev;
    logic   m_saw, m_end;

    function automatic logic m_tri();
        return !m_saw && (m_s < m_e);
    endfunction

    task automatic model_out(output logic [15:0] c, output logic d);
        longint L, q;
        if (m_tri()) begin
            L = m_e - m_s;
            if (m_p == 0) begin
                c = 16'(m_s); d = 1'b0;
            end else begin
                q = ((m_p - 1) % (2 * L)) + 1;
                c = 16'((q <= L) ? m_s + q : m_s + 2 * L - q);
                d = (q > L);
            end
        end else begin
            L = (m_e - m_s) & 64'hFFFF;
            c = 16'((m_s + (m_p % (L + 1))) & 64'hFFFF);
            d = 1'b0;
        end
    endtask

    function automatic logic model_wrap();
        longint L;
        if (m_tri()) begin
            L = m_e - m_s;
            return (m_p > 1) && (((m_p - 1) % (2 * L)) == 0);
        end
        L = (m_e - m_s) & 64'hFFFF;
        return (m_p % (L + 1)) == 0;
    endfunction

    task automatic model_clock();
        logic tick;
        if (rst_i) begin
            m_s = 0; m_e = 0; m_saw = 1'b1; m_presc = 0; m_p = 0; m_qev = 0; m_end = 1'b0;
        end else if (ctrl_update_i) begin
            m_s = cfg_start_i; m_e = cfg_end_i; m_saw = cfg_saw_i;
`ifdef TIMER_EVENT_COUNTER_PRESC_EN
            m_presc = cfg_presc_i;
`else
            m_presc = 0;
`endif
            m_p = 0; m_qev = 0; m_end = 1'b0;
        end else if (ctrl_rst_i) begin
            m_p = 0; m_qev = 0; m_end = 1'b0;
        end else begin
            m_end = 1'b0;
            if (ctrl_active_i && event_i) begin
                // every (presc+1)-th qualified event is a step
                tick  = (m_qev % (m_presc + 1)) == m_presc;
                m_qev = m_qev + 1;
                if (tick) begin
                    m_p   = m_p + 1;
                    m_end = model_wrap();
                end
            end
        end
    endtask

    // One clock: drive inputs, take the edge, advance model, compare #1 later.
    task automatic cyc(input logic rst, act, upd, crst, ev,
                       input logic [15:0] st, en, input logic saw, input logic [7:0] ps);
        logic [15:0] ec;
        logic        ed;
        rst_i = rst; ctrl_active_i = act; ctrl_update_i = upd; ctrl_rst_i = crst;
        event_i = ev; cfg_start_i = st; cfg_end_i = en; cfg_saw_i = saw; cfg_presc_i = ps;
        @(posedge clk_i);
        model_clock();
        #1;
        model_out(ec, ed);
        check("model_counter", counter_o, ec);
        check("model_direction", direction_o, ed);
        check("model_end", end_o, m_end);
    endtask

    typedef struct {
        logic        rst, act, upd, crst, ev;
        logic [15:0] st, en;
        logic        saw;
        logic [15:0] ec;
        logic        ed, ee;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, act, upd, crst, ev, logic [15:0] st, en,
                                logic saw, logic [15:0] ec, logic ed, ee);
        vec_t v;
        v.rst = rst; v.act = act; v.upd = upd; v.crst = crst; v.ev = ev;
        v.st = st; v.en = en; v.saw = saw; v.ec = ec; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    // A plain step row. Its config inputs are junk and must be ignored.
    function automatic vec_t st1(logic act, ev, logic [15:0] ec, logic ed, ee);
        return mk(0, act, 0, 0, ev, 16'hAAAA, 16'h5555, 1'b0, ec, ed, ee);
    endfunction

    initial begin
        int ends;
        // reset, then start=end=0 default shadows: pulse every step
        vq.push_back(mk(1,1,0,0,1, 0,0,1, 16'h0,0,0));
        vq.push_back(mk(1,1,0,0,1, 0,0,1, 16'h0,0,0));
        vq.push_back(st1(1,1, 16'h0,0,1));
        vq.push_back(st1(1,1, 16'h0,0,1));
        // sawtooth 3..6
        vq.push_back(mk(0,1,1,0,1, 3,6,1, 16'd3,0,0));
        vq.push_back(st1(1,1, 16'd4,0,0));
        vq.push_back(st1(1,1, 16'd5,0,0));
        vq.push_back(st1(1,1, 16'd6,0,0));
        vq.push_back(st1(1,1, 16'd3,0,1));
        vq.push_back(st1(1,1, 16'd4,0,0));
        // triangle 2..5
        vq.push_back(mk(0,1,1,0,1, 2,5,0, 16'd2,0,0));
        vq.push_back(st1(1,1, 16'd3,0,0));
        vq.push_back(st1(1,1, 16'd4,0,0));
        vq.push_back(st1(1,1, 16'd5,0,0));
        vq.push_back(st1(1,1, 16'd4,1,0));
        vq.push_back(st1(1,1, 16'd3,1,0));
        vq.push_back(st1(1,1, 16'd2,1,0));
        vq.push_back(st1(1,1, 16'd3,0,1));
        vq.push_back(st1(1,1, 16'd4,0,0));
        // update beats ctrl_rst; event gating; inactive freeze
        vq.push_back(mk(0,1,1,1,1, 7,9,1, 16'd7,0,0));
        vq.push_back(st1(1,0, 16'd7,0,0));
        vq.push_back(st1(1,1, 16'd8,0,0));
        vq.push_back(st1(1,0, 16'd8,0,0));
        vq.push_back(st1(1,1, 16'd9,0,0));
        vq.push_back(st1(1,1, 16'd7,0,1));
        vq.push_back(st1(0,1, 16'd7,0,0));
        vq.push_back(st1(0,1, 16'd7,0,0));
        // ctrl_rst mid-descent returns to r_start, direction up
        vq.push_back(mk(0,1,1,0,1, 2,5,0, 16'd2,0,0));
        vq.push_back(st1(1,1, 16'd3,0,0));
        vq.push_back(st1(1,1, 16'd4,0,0));
        vq.push_back(st1(1,1, 16'd5,0,0));
        vq.push_back(st1(1,1, 16'd4,1,0));
        vq.push_back(mk(0,1,0,1,1, 9,9,1, 16'd2,0,0));
        vq.push_back(st1(1,1, 16'd3,0,0));
        // wrap through all-ones
        vq.push_back(mk(0,1,1,0,1, 16'hFFFE,16'h0001,1, 16'hFFFE,0,0));
        vq.push_back(st1(1,1, 16'hFFFF,0,0));
        vq.push_back(st1(1,1, 16'h0000,0,0));
        vq.push_back(st1(1,1, 16'h0001,0,0));
        vq.push_back(st1(1,1, 16'hFFFE,0,1));
        vq.push_back(st1(1,1, 16'hFFFF,0,0));
        // degenerate triangle start==end
        vq.push_back(mk(0,1,1,0,1, 4,4,0, 16'd4,0,0));
        vq.push_back(st1(1,1, 16'd4,0,1));
        vq.push_back(st1(1,1, 16'd4,0,1));

        foreach (vq[i]) begin
            cyc(vq[i].rst, vq[i].act, vq[i].upd, vq[i].crst, vq[i].ev,
                vq[i].st, vq[i].en, vq[i].saw, 8'd0);
            check($sformatf("vec%0d_counter", i), counter_o, vq[i].ec);
            check($sformatf("vec%0d_direction", i), direction_o, vq[i].ed);
            check($sformatf("vec%0d_end", i), end_o, vq[i].ee);
        end

        // prescale 2, sawtooth 0..3, 12 continuous events
        cyc(0,1,1,0,1, 16'd0, 16'd3, 1'b1, 8'd2);
        ends = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0,1,0,0,1, 16'h1111, 16'h2222, 1'b0, 8'd7);
            ends += end_o;
        end
`ifdef TIMER_EVENT_COUNTER_PRESC_EN
        check("presc_end_count", ends, 1);
`else
        check("presc_end_count", ends, 3);
`endif

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] s, e;
            if ($urandom_range(0, 3) == 0) begin
                s = 16'($urandom); e = 16'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    s = 16'hFFF0 + 16'($urandom_range(0, 15)); e = 16'($urandom_range(0, 15));
                end
            end else begin
                s = 16'($urandom_range(0, 12)); e = 16'($urandom_range(0, 12));
            end
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) < 6, s, e, 1'($urandom), 8'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_event_counter.md
Name: timer_event_counter

Overview:
- Counting stage directly downstream of the timer input stage. It consumes the per-cycle event qualifier from the input stage and advances a NUM_BITS counter between programmable start and end thresholds.
- Two period shapes: sawtooth (up, wrap to start) and triangle (up to end, down to start).
- end_o feeds the input stage's cnt_end_i, which disarms it, and also feeds the downstream comparators.

Parameters:
- NUM_BITS, 16, counter and threshold width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- ctrl_active_i  in  1  counting enable; steps are ignored when low.
- ctrl_update_i  in  1  loads shadow config and restarts the counter.
- ctrl_rst_i  in  1  restarts the counter without reloading config.
- cfg_start_i  in  NUM_BITS  start threshold.
- cfg_end_i  in  NUM_BITS  end threshold.
- cfg_saw_i  in  1  1 = sawtooth, 0 = triangle.
- cfg_presc_i  in  8  event prescale value, used only with the optional feature.
- event_i  in  1  step qualifier from the input stage.
- counter_o  out  NUM_BITS  current count.
- direction_o  out  1  0 = counting up, 1 = counting down.
- end_o  out  1  one-cycle end-of-period pulse, registered.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: every register is cleared on a clk_i edge while rst_i=1.
- Reset values:
  - counter_o=0, direction_o=0, end_o=0.
  - Shadow registers: r_start=0, r_end=0, r_saw=1.
  - Prescaler counter = 0.
- Priority per cycle, highest first: rst_i > ctrl_update_i > ctrl_rst_i > step.
- ctrl_update_i:
  - r_start/r_end/r_saw(/r_presc) <= cfg inputs.
  - counter <= cfg_start_i, using the new value directly rather than the shadow.
  - direction <= 0; prescaler counter <= 0; end_o <= 0.
- ctrl_rst_i: counter <= r_start; direction <= 0; prescaler counter <= 0; end_o <= 0.
- step = ctrl_active_i & event_i & tick. tick=1 always unless the optional feature is enabled.
- Sawtooth (r_saw=1), on step:
  - If counter==r_end: counter <= r_start, end_o <= 1.
  - Otherwise: counter <= counter+1, modulo 2^NUM_BITS.
  - If r_start > r_end, the counter wraps through all-ones to 0 and continues until it equals r_end.
- Triangle (r_saw=0, r_start<r_end), on step:
  - Up and counter==r_end: direction <= 1, counter <= counter-1.
  - Up otherwise: counter+1.
  - Down and counter==r_start: direction <= 0, counter <= counter+1, end_o <= 1.
  - Down otherwise: counter-1.
  - Period = 2*(r_end-r_start) steps.
- Triangle with r_start>=r_end: behaves exactly as sawtooth, with direction_o held at 0.
- r_start==r_end, either mode: every step pulses end_o; counter stays at r_start.
- end_o:
  - High for exactly the one cycle after the wrapping step; cleared the next cycle unless another wrapping step occurs.
  - Back-to-back wrapping steps produce back-to-back high cycles.
- Latency: counter_o and end_o reflect a step one cycle after event_i is sampled.
- ctrl_active_i=0:
  - counter, direction and prescaler are frozen; end_o clears.
  - ctrl_update_i and ctrl_rst_i still take effect.
- Config inputs have no effect between updates.

Optional Feature:
- Macro: TIMER_EVENT_COUNTER_PRESC_EN.
- Defined:
  - 8-bit shadow r_presc is loaded by ctrl_update_i; an 8-bit prescaler counter increments on each ctrl_active_i&event_i.
  - tick=1 when prescaler counter==r_presc, and the prescaler counter then returns to 0.
  - The counter therefore advances once every r_presc+1 qualified events; r_presc=0 means every event.
- Not defined: cfg_presc_i is ignored, no prescaler registers exist, and tick is tied to 1.

Test Plan:
- Reset: assert rst_i for 2 cycles while event_i=1 -> counter_o=0, direction_o=0, end_o=0. Deassert with start=end=0 and active=1 -> end_o high every cycle, counter_o stays 0.
- Sawtooth: update start=3, end=6, saw=1; event_i=1 constant -> counter_o 3,4,5,6,3,… and end_o high the cycle counter_o returns to 3, once per 4 events.
- Triangle: update start=2, end=5, saw=0 -> counter_o 2,3,4,5,4,3,2,3,…; direction_o=1 while descending; end_o once per 6 steps, the cycle after 2 is reached descending.
- Gating and priority:
  - Toggle event_i every other cycle -> counter advances only on event cycles.
  - ctrl_active_i=0 -> counter frozen.
  - ctrl_update_i and ctrl_rst_i in the same cycle -> update wins, counter=cfg_start_i.
  - ctrl_rst_i mid-descent -> counter=r_start, direction_o=0.
- Wrap: NUM_BITS=16, saw, start=0xFFFE, end=0x0001 -> counter_o FFFE,FFFF,0000,0001,FFFE with end_o once.
- With TIMER_EVENT_COUNTER_PRESC_EN, cfg_presc_i=2, saw start=0 end=3, event_i=1 -> counter increments every 3rd cycle; end_o once per 12 events. Without the macro, the same stimulus increments every cycle.
